pe_bf16_operand_driver: RTL

- Initiator side of the bfloat16 PE load/done handshake.
- Holds a small host-written buffer of (row, col) bfloat16 operand pairs and clears the PE accumulator.
- Issues one load_in pulse per pair, waits for done_pe before each next issue, and returns the PE's final accumulated dot-product result to the host.
- Used to drive single PEs in standalone matrix-multiplier tests and as the edge feeder of a PE row.

---
 rtl/bf16_pe_pkg.sv | 24 ++
 rtl/pe_operand_buffer.sv | 25 ++
 rtl/pe_bf16_operand_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bf16_pe_pkg.sv
// Shared types and constants for the bfloat16 PE operand driver and its benches.
package bf16_pe_pkg;

  localparam int unsigned BF16_W = 16;

  localparam logic [BF16_W-1:0] BF16_ZERO  = 16'h0000;
  localparam logic [BF16_W-1:0] BF16_ONE   = 16'h3F80;
  localparam logic [BF16_W-1:0] BF16_TWO   = 16'h4000;
  localparam logic [BF16_W-1:0] BF16_THREE = 16'h4040;
  localparam logic [BF16_W-1:0] BF16_FOUR  = 16'h4080;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR  = 3'd1;
  localparam logic [ST_W-1:0] ST_ISSUE  = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd3;
  localparam logic [ST_W-1:0] ST_FINISH = 3'd4;

  typedef struct packed {
    logic [BF16_W-1:0] row;
    logic [BF16_W-1:0] col;
  } operand_pair_t;

endpackage

// File: rtl/pe_operand_buffer.sv
// DEPTH-entry register file of (row, col) bfloat16 operand pairs; one write port, async read.
module pe_operand_buffer
  import bf16_pe_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  operand_pair_t wdata,
  input  logic [AW-1:0] raddr,
  output operand_pair_t rdata_c
);

  operand_pair_t mem [DEPTH];

  // Contents deliberately survive reset so a run can be repeated after an abort.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/pe_bf16_operand_driver.sv
// Initiator for the bfloat16 PE load/done handshake: clears the PE, streams buffered
// operand pairs one at a time, and returns the final accumulated result to the host.
module pe_bf16_operand_driver
  import bf16_pe_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BF16_W-1:0] wr_row,
  input  logic [BF16_W-1:0] wr_col,
  input  logic [AW:0]       len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [BF16_W-1:0] result,
  output logic              timeout_err,
  output logic              pe_clr,
  output logic              load_in,
  output logic [BF16_W-1:0] row_in,
  output logic [BF16_W-1:0] col_in,
  input  logic [BF16_W-1:0] pe_result_in,
  input  logic              done_pe
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [ST_W-1:0]   state, state_n;
  logic [AW-1:0]     idx, idx_n, last, last_n;
  logic [TW-1:0]     timer, timer_n;
  logic              busy_n, done_n, timeout_err_n, pe_clr_n, load_in_n;
  logic [BF16_W-1:0] result_n, row_in_n, col_in_n;
  logic [AW-1:0]     len_last;
  operand_pair_t     rd_pair;

  pe_operand_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .we      (wr_en & ~busy),
    .waddr   (wr_addr),
    .wdata   ('{row: wr_row, col: wr_col}),
    .raddr   (idx),
    .rdata_c (rd_pair)
  );

  // Index of the final pair, with len saturated to DEPTH.
  assign len_last = (len > (AW+1)'(DEPTH)) ? AW'(DEPTH - 1) : AW'(len - (AW+1)'(1));

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    last_n        = last;
    timer_n       = timer;
    busy_n        = busy;
    done_n        = 1'b0;
    result_n      = result;
    timeout_err_n = timeout_err;
    pe_clr_n      = 1'b0;
    load_in_n     = 1'b0;
    row_in_n      = row_in;
    col_in_n      = col_in;
    case (state)
      ST_IDLE: begin
        if (start) begin
          timeout_err_n = 1'b0;
          if (len == '0) begin
            done_n   = 1'b1;
            result_n = BF16_ZERO;
            state_n  = ST_FINISH;
          end else begin
            last_n  = len_last;
            idx_n   = '0;
            busy_n  = 1'b1;
            state_n = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        pe_clr_n = 1'b1;
        state_n  = ST_ISSUE;
      end
      ST_ISSUE: begin
        load_in_n = 1'b1;
        row_in_n  = rd_pair.row;
        col_in_n  = rd_pair.col;
        timer_n   = '0;
        state_n   = ST_WAIT;
      end
      ST_WAIT: begin
        timer_n = timer + TW'(1);
        // A response in the last timer cycle still counts as a completion.
        if (done_pe) begin
          if (idx == last) begin
            result_n = pe_result_in;
            done_n   = 1'b1;
            busy_n   = 1'b0;
            state_n  = ST_FINISH;
          end else begin
            idx_n   = idx + AW'(1);
            state_n = ST_ISSUE;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_err_n = 1'b1;
          done_n        = 1'b1;
          busy_n        = 1'b0;
          state_n       = ST_FINISH;
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      last        <= '0;
      timer       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= BF16_ZERO;
      timeout_err <= 1'b0;
      pe_clr      <= 1'b0;
      load_in     <= 1'b0;
      row_in      <= BF16_ZERO;
      col_in      <= BF16_ZERO;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      last        <= last_n;
      timer       <= timer_n;
      busy        <= busy_n;
      done        <= done_n;
      result      <= result_n;
      timeout_err <= timeout_err_n;
      pe_clr      <= pe_clr_n;
      load_in     <= load_in_n;
      row_in      <= row_in_n;
      col_in      <= col_in_n;
    end
  end

endmodule
